fnd_scan: RTL and testbench
===========================

# fnd_scan

Multiplexed N-digit seven-segment (FND) scan driver for the doorlock front panel. It generalises the single-digit FND decoder to a parametrised digit count with a time-multiplexed common drive and double-buffered digit data. It also adds per-digit blinking and a ghosting guard slot. The doorlock controller loads digit codes; this block refreshes the panel autonomously.

## Interface
- DIGITS, 4: number of digits scanned (1..8)
- SCAN_DIV, 1000: clock cycles per digit slot (≥2)
- BLINK_FRAMES, 250: scan frames per blink half-period (≥1)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  scan enable; low blanks panel and holds counters at 0
- load  in  1  one-cycle strobe: capture digits_in/blink_mask into pending buffer
- digits_in  in  4*DIGITS  digit codes, digit k at bits [4k+3:4k]
- blink_mask  in  DIGITS  bit k=1: digit k blinks
- seg  out  7  segments {a,b,c,d,e,f,g}, bit6=a, active-low (0 = lit)
- com  out  DIGITS  digit commons, active-low, one-hot-low or all high
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Code map (seg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=1111111 (blank), B=1001000 (reject "X"), C..F=1111111.
- Pending buffer: on load, digits_in/blink_mask copied to pending regs and pending flag set; a later load before commit overwrites (last wins).
- Display buffer: copied from pending at frame wrap when pending flag set; flag cleared. A load in the commit cycle is not committed then; it stays pending for the next wrap.
- Prescaler p counts 0..SCAN_DIV-1; at SCAN_DIV-1 digit index i advances, wrapping DIGITS-1→0 (frame wrap).
- Slot output: p==0 → guard: com all high, seg 7F. Otherwise com[i]=0, others 1, seg=map(display[i]), or 7F if blink_phase=1 and display blink bit i set.
- Blink: frame counter 0..BLINK_FRAMES-1 increments on each frame wrap; at its terminal value it wraps and blink_phase toggles.
- enable=0: p, i, frame counter, blink_phase synchronously cleared; com all high, seg 7F, frame_done 0. Pending/display buffers and load still operate, but no commit occurs (no wrap).
- Reset: p=0, i=0, frame counter 0, blink_phase 0, display codes all A (blank), display mask 0, pending flag 0; seg=7'h7F, com all ones, frame_done=0.

## Timing
- All outputs registered; they reflect counter state of the previous cycle (1-cycle latency).
- After rst_n rises with enable high: edge 1 → guard; com[0] low from edge 2 for SCAN_DIV-1 cycles, then one guard cycle, then com[1], ... Frame = DIGITS*SCAN_DIV cycles.
- frame_done high for exactly one cycle, coincident with the guard cycle of slot 0 that follows slot DIGITS-1. Never at the first frame after reset/enable.
- Committed data is visible starting from the slot-0 drive immediately after that guard cycle.
- Reset mid-frame: outputs go to reset values asynchronously; scan restarts at slot 0.
- enable low→high: behaves as after reset release (edge 1 guard, edge 2 com[0]).
- Never more than one com bit low; guard cycle always separates consecutive digits.

## Test plan
- DIGITS=4, SCAN_DIV=4: reset, enable=1, no load → com sequence E,(guard F),D,B,7 low-pattern per slot each 3 cycles, seg=7F throughout, frame_done every 16 cycles.
- load digits_in=16'h1234 mid-frame → old blank continues to wrap; from next slot 0: digit0 seg=0010010? no: digit0=code 4 → seg 1001100, digit1=3 → 0000110, digit2=2, digit3=1.
- Two loads in one frame (16'h1111 then 16'h9090) → only 9090 displayed; load in commit cycle with 16'h5555 → shown one frame later.
- BLINK_FRAMES=2, blink_mask=4'b0010, digits 16'h8888 → digit1 seg alternates 0000000 / 7F every 2 frames; other digits steady 0000000.
- Codes A, B, F → 7F, 1001000, 7F; enable dropped mid-slot → next cycle com=F, seg=7F, counters 0; re-enable → com[0] low at edge 2.
- Assert rst_n=0 asynchronously mid-slot → seg=7F, com all high immediately; display reverts to blank.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Front-panel bus between the doorlock controller and the FND scan driver.
// The controller owns the load/enable side; the scanner drives the panel pins.
interface fnd_scan_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     blink_mask;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     com;
    logic                  frame_done;

    modport master (
        output enable, load, digits_in, blink_mask,
        input  seg, com, frame_done
    );
    modport slave (
        input  enable, load, digits_in, blink_mask,
        output seg, com, frame_done
    );
endinterface

// File: rtl/fnd_scan.sv
// Multiplexed N-digit seven-segment scan driver with double-buffered digit
// data, per-digit blinking and a blanked guard cycle between digit slots.
module fnd_digit_lane (
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (code)
                4'h0:    seg = 7'b0000001;
                4'h1:    seg = 7'b1001111;
                4'h2:    seg = 7'b0010010;
                4'h3:    seg = 7'b0000110;
                4'h4:    seg = 7'b1001100;
                4'h5:    seg = 7'b0100100;
                4'h6:    seg = 7'b0100000;
                4'h7:    seg = 7'b0001111;
                4'h8:    seg = 7'b0000000;
                4'h9:    seg = 7'b0000100;
                4'hB:    seg = 7'b1001000;
                default: seg = 7'h7F;
            endcase
        end
    end
endmodule

module fnd_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    fnd_scan_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]               p;
    logic [IW-1:0]               i;
    logic [FW-1:0]               fc;
    logic                        phase;
    logic                        wrap_q;
    logic [DIGITS-1:0][3:0]      pend_code, disp_code;
    logic [DIGITS-1:0]           pend_mask, disp_mask;
    logic                        pend_flag;
    logic [DIGITS-1:0][6:0]      lane_seg;
    logic                        wrap, commit;

    assign wrap   = bus.enable && (p == P_LAST) && (i == I_LAST);
    assign commit = wrap && pend_flag;

    for (genvar k = 0; k < DIGITS; k++) begin : g_lane
        fnd_digit_lane u_lane (
            .code  (disp_code[k]),
            .blank (phase & disp_mask[k]),
            .seg   (lane_seg[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p              <= '0;
            i              <= '0;
            fc             <= '0;
            phase          <= 1'b0;
            wrap_q         <= 1'b0;
            pend_code      <= '0;
            pend_mask      <= '0;
            pend_flag      <= 1'b0;
            disp_code      <= {DIGITS{4'hA}};
            disp_mask      <= '0;
            bus.seg        <= 7'h7F;
            bus.com        <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            // A load in the commit cycle lands in pending after the copy,
            // so it waits for the next wrap.
            if (bus.load) begin
                pend_code <= bus.digits_in;
                pend_mask <= bus.blink_mask;
            end
            pend_flag <= bus.load | (pend_flag & ~commit);
            if (commit) begin
                disp_code <= pend_code;
                disp_mask <= pend_mask;
            end

            if (!bus.enable) begin
                p              <= '0;
                i              <= '0;
                fc             <= '0;
                phase          <= 1'b0;
                wrap_q         <= 1'b0;
                bus.seg        <= 7'h7F;
                bus.com        <= '1;
                bus.frame_done <= 1'b0;
            end else begin
                // p==0 is the guard slot: all commons off to kill ghosting.
                bus.seg        <= (p == '0) ? 7'h7F : lane_seg[i];
                bus.com        <= (p == '0) ? '1 : ~(DIGITS'(1) << i);
                wrap_q         <= wrap;
                bus.frame_done <= wrap_q;
                if (p == P_LAST) begin
                    p <= '0;
                    i <= (i == I_LAST) ? '0 : i + 1'b1;
                end else begin
                    p <= p + 1'b1;
                end
                if (wrap) begin
                    fc <= (fc == F_LAST) ? '0 : fc + 1'b1;
                    if (fc == F_LAST) phase <= ~phase;
                end
            end
        end
    end
endmodule

// File: tb/tb_fnd_scan.sv
// Scoreboard bench for fnd_scan: the stimulus side pushes per-cycle expected
// panel state, a negedge monitor pops and compares.
module tb_fnd_scan;
    localparam int D  = 4;
    localparam int S  = 4;
    localparam int BF = 2;
    localparam int FR = D * S;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] com;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    fnd_scan_if #(.DIGITS(D)) bus ();

    fnd_scan #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b1111111, 7'b1001000,
                                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    // model state
    int         n, fc;
    bit         ph, pflag;
    logic [3:0] disp [D];
    logic [3:0] dmask, pmask, cur_bm;
    logic [15:0] pend, cur_din;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got seg=%b com=%b fd=%b, want seg=%b com=%b fd=%b",
                     name, got[11:5], got[4:1], got[0], want[11:5], want[4:1], want[0]);
        end
    endtask

    task automatic model_reset();
        n = 0; fc = 0; ph = 0; pflag = 0;
        dmask = '0; pmask = '0; pend = '0;
        for (int k = 0; k < D; k++) disp[k] = 4'hA;
    endtask

    task automatic cyc(input bit en, input bit ld);
        exp_t e;
        int m, q, d, f;
        bus.enable = en; bus.load = ld;
        bus.digits_in = cur_din; bus.blink_mask = cur_bm;
        e.seg = 7'h7F; e.com = 4'hF; e.fd = 1'b0;
        if (!en) begin
            n = 0; fc = 0; ph = 0;
        end else begin
            m = n; q = m % S; d = (m / S) % D; f = m / FR;
            if (q == 0) begin
                e.fd = (d == 0) && (f > 0);
            end else begin
                e.com = 4'hF & ~(4'b0001 << d);
                e.seg = (ph && dmask[d]) ? 7'h7F : segtab[disp[d]];
            end
            if (m % FR == FR - 1) begin
                if (pflag) begin
                    for (int k = 0; k < D; k++) disp[k] = pend[4*k +: 4];
                    dmask = pmask; pflag = 0;
                end
                if (fc == BF - 1) begin fc = 0; ph = ~ph; end
                else fc++;
            end
            n++;
        end
        if (ld) begin pend = cur_din; pmask = cur_bm; pflag = 1; end
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic run(input int k);
        repeat (k) cyc(1, 0);
    endtask

    task automatic run_until(input int pos);
        while (n % FR != pos) cyc(1, 0);
    endtask

    task automatic do_load(input logic [15:0] din, input logic [3:0] bm);
        cur_din = din; cur_bm = bm;
        cyc(1, 1);
    endtask

    task automatic async_reset();
        exp_t e;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", {bus.seg, bus.com, bus.frame_done}, {7'h7F, 4'hF, 1'b0});
        model_reset();
        e.seg = 7'h7F; e.com = 4'hF; e.fd = 1'b0;
        sbq.push_back(e);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // monitor: the panel presents a new state every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("panel", {bus.seg, bus.com, bus.frame_done}, {e.seg, e.com, e.fd});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0; bus.load = 1'b0;
        bus.digits_in = '0; bus.blink_mask = '0;
        cur_din = '0; cur_bm = '0;
        model_reset();
        #12;
        check("reset_state", {bus.seg, bus.com, bus.frame_done}, {7'h7F, 4'hF, 1'b0});
        rst_n = 1'b1;

        // blank scan, guard slots and frame_done cadence
        run(40);
        // single load mid-frame
        run_until(6);
        do_load(16'h1234, 4'b0000);
        run(40);
        // last load wins, load in the commit cycle waits a frame
        run_until(5);
        do_load(16'h1111, 4'b0000);
        run_until(9);
        do_load(16'h9090, 4'b0000);
        run_until(15);
        do_load(16'h5555, 4'b0000);
        run(40);
        // blinking digit 1
        run_until(3);
        do_load(16'h8888, 4'b0010);
        run(100);
        // remaining codes
        run_until(2);
        do_load(16'hFBA0, 4'b0000);
        run(40);
        run_until(2);
        do_load(16'h76DE, 4'b0000);
        run(40);
        // enable dropped mid-slot then restored
        run_until(6);
        repeat (3) cyc(0, 0);
        run(24);
        // async reset mid-slot: display back to blank
        run_until(7);
        async_reset();
        run(24);

        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
